wb_dual_stage: RTL
==================

Name: wb_dual_stage

Overview:
- Dual-lane MEM/WB pipeline register and writeback-select stage for the two-issue MIPS pipeline.
- Captures both lanes' MEM results on r_clk posedge and selects ALU or load data per lane.
- Drives the two register-file write ports (wr_en/addr/data for lanes 1 and 2). The register file commits on the following negedge.
- Resolves same-destination write conflicts, suppresses $zero writes, exposes WB-stage values for forwarding, and counts retired instructions.

Parameters:
- AWIDTH, 5, register address width
- DWIDTH, 32, data width
- CWIDTH, 32, retire counter width

Ports:
- r_clk  in  1  clock; stage register updates on posedge
- r_rst  in  1  reset, asynchronous, active-low
- i_stall  in  1  hold WB register contents
- i_flush  in  1  invalidate both lanes on next posedge
- i_valid_1 / i_valid_2  in  1  lane carries a real instruction
- i_reg_wr_1 / i_reg_wr_2  in  1  instruction writes a register
- i_mem_to_reg_1 / i_mem_to_reg_2  in  1  1 = load data, 0 = ALU result
- i_addr_rd_1 / i_addr_rd_2  in  AWIDTH  destination register
- i_alu_1 / i_alu_2  in  DWIDTH  ALU result
- i_mem_1 / i_mem_2  in  DWIDTH  load data
- o_wr_en_1 / o_wr_en_2  out  1  register-file write enable
- o_addr_rd_1 / o_addr_rd_2  out  AWIDTH  write address
- o_data_rd_1 / o_data_rd_2  out  DWIDTH  write data (also the forwarding source)
- o_valid_1 / o_valid_2  out  1  WB lane occupied
- o_retired  out  CWIDTH  retired-instruction count

Behaviour:
- Reset (r_rst=0, any time, including mid-stall):
  - All stage registers and the counter clear to 0 immediately.
  - All outputs read 0 while reset is held.
- Posedge, priority order i_flush > i_stall > load:
  - flush: valid_1 and valid_2 clear to 0; other fields don't-care but are held.
  - stall: all stage registers hold.
  - otherwise: latch all lane inputs.
- Latency: one cycle from inputs to outputs. Register-file write lands on the negedge of the same cycle the outputs appear.
- Outputs are combinational from stage registers only; there are no input-to-output combinational paths.
  - o_data_rd_n = mem_to_reg_n ? mem_n : alu_n (registered values).
  - o_addr_rd_n = registered rd_n.
  - o_valid_n = registered valid_n.
- Write enables:
  - o_wr_en_2 = valid_2 & reg_wr_2 & (rd_2 != 0).
  - o_wr_en_1 = valid_1 & reg_wr_1 & (rd_1 != 0) & ~(o_wr_en_2 & rd_1 == rd_2).
  - Lane 1 is older in program order, so lane 2 wins a same-rd conflict. The two write ports are never enabled with equal addresses.
- Invalid or non-writing lanes never assert wr_en, regardless of address or data.
- Retire counter:
  - On each posedge with r_rst=1 and i_stall=0, o_retired += o_valid_1 + o_valid_2, using values before the edge.
  - Held stall contents are not double counted.
  - Flush does not block counting of the lanes currently in WB.
  - Wraps modulo 2^CWIDTH with no saturation.
- Simultaneous stall+flush: flush wins and the counter still updates (i_stall=1 blocks counting only when flush=0).

Test Plan:
- Reset: assert r_rst=0 mid-run with both lanes valid and counter=7 -> all outputs 0 immediately, o_retired=0; after release with zero inputs, outputs stay 0.
- Basic dual write: lane1 rd=3 alu=0x11 mem_to_reg=0; lane2 rd=4 mem=0xAB mem_to_reg=1; both valid/reg_wr -> next cycle wr_en=1/1, addr=3/4, data=0x11/0xAB; o_retired increments by 2 on the following edge.
- Conflict/zero: lane1 rd=5 data=1, lane2 rd=5 data=2 -> wr_en_1=0, wr_en_2=1, data=2. Then lane1 rd=0 reg_wr=1 -> wr_en_1=0 while o_valid_1=1.
- Stall: load lanes, then i_stall=1 for 3 cycles with changing inputs -> outputs frozen, o_retired unchanged over the stall; release -> new inputs appear one cycle later.
- Flush priority: i_stall=1 and i_flush=1 together with both lanes valid -> next cycle o_valid_1/2=0 and wr_en=0; counter +2 for the flushed-out occupants.
- Counter wrap with CWIDTH=4: drive 8 cycles of dual-valid -> o_retired goes 14 -> 0 (mod 16) on the eighth increment.

Source files
------------

// File: rtl/wb_dual_stage.sv
// wb_dual_stage: dual-lane MEM/WB pipeline register with writeback select, conflict resolution and retire counter
//
// Ports:
//   r_clk, r_rst                 clock (posedge) and asynchronous active-low reset
//   i_stall, i_flush             hold stage contents / invalidate both lanes (flush wins)
//   i_valid_n, i_reg_wr_n        lane occupancy and register-write intent
//   i_mem_to_reg_n               select load data (1) or ALU result (0)
//   i_addr_rd_n, i_alu_n, i_mem_n  destination, ALU result, load data
//   o_wr_en_n, o_addr_rd_n, o_data_rd_n  register-file write ports (data also feeds forwarding)
//   o_valid_n                    WB lane occupied
//   o_retired                    retired-instruction count, wraps modulo 2^CWIDTH
module wb_dual_stage #(
   parameter int AWIDTH = 5,
   parameter int DWIDTH = 32,
   parameter int CWIDTH = 32
) (
   input  logic              r_clk,
   input  logic              r_rst,
   input  logic              i_stall,
   input  logic              i_flush,
   input  logic              i_valid_1,
   input  logic              i_valid_2,
   input  logic              i_reg_wr_1,
   input  logic              i_reg_wr_2,
   input  logic              i_mem_to_reg_1,
   input  logic              i_mem_to_reg_2,
   input  logic [AWIDTH-1:0] i_addr_rd_1,
   input  logic [AWIDTH-1:0] i_addr_rd_2,
   input  logic [DWIDTH-1:0] i_alu_1,
   input  logic [DWIDTH-1:0] i_alu_2,
   input  logic [DWIDTH-1:0] i_mem_1,
   input  logic [DWIDTH-1:0] i_mem_2,
   output logic              o_wr_en_1,
   output logic              o_wr_en_2,
   output logic [AWIDTH-1:0] o_addr_rd_1,
   output logic [AWIDTH-1:0] o_addr_rd_2,
   output logic [DWIDTH-1:0] o_data_rd_1,
   output logic [DWIDTH-1:0] o_data_rd_2,
   output logic              o_valid_1,
   output logic              o_valid_2,
   output logic [CWIDTH-1:0] o_retired
);
   logic              r_valid_1, r_valid_2, r_reg_wr_1, r_reg_wr_2, r_mtr_1, r_mtr_2;
   logic [AWIDTH-1:0] r_rd_1, r_rd_2;
   logic [DWIDTH-1:0] r_alu_1, r_alu_2, r_mem_1, r_mem_2;
   logic [CWIDTH-1:0] r_retired;
   logic              w_wr_en_1, w_wr_en_2;

   always_ff @(posedge r_clk or negedge r_rst)
      if (!r_rst) begin
         r_valid_1  <= 1'b0;
         r_valid_2  <= 1'b0;
         r_reg_wr_1 <= 1'b0;
         r_reg_wr_2 <= 1'b0;
         r_mtr_1    <= 1'b0;
         r_mtr_2    <= 1'b0;
         r_rd_1     <= '0;
         r_rd_2     <= '0;
         r_alu_1    <= '0;
         r_alu_2    <= '0;
         r_mem_1    <= '0;
         r_mem_2    <= '0;
         r_retired  <= '0;
      end else begin
         // Occupants leave WB on any non-stalled edge, flush included, so they retire then.
         if (i_flush || !i_stall)
            r_retired <= r_retired + CWIDTH'(r_valid_1) + CWIDTH'(r_valid_2);
         if (i_flush) begin
            r_valid_1 <= 1'b0;
            r_valid_2 <= 1'b0;
         end else if (!i_stall) begin
            r_valid_1  <= i_valid_1;
            r_valid_2  <= i_valid_2;
            r_reg_wr_1 <= i_reg_wr_1;
            r_reg_wr_2 <= i_reg_wr_2;
            r_mtr_1    <= i_mem_to_reg_1;
            r_mtr_2    <= i_mem_to_reg_2;
            r_rd_1     <= i_addr_rd_1;
            r_rd_2     <= i_addr_rd_2;
            r_alu_1    <= i_alu_1;
            r_alu_2    <= i_alu_2;
            r_mem_1    <= i_mem_1;
            r_mem_2    <= i_mem_2;
         end
      end

   // Lane 2 is younger, so on a shared destination its write is the one that must land.
   assign w_wr_en_2 = r_valid_2 & r_reg_wr_2 & (r_rd_2 != '0);
   assign w_wr_en_1 = r_valid_1 & r_reg_wr_1 & (r_rd_1 != '0) & ~(w_wr_en_2 & (r_rd_1 == r_rd_2));

   assign o_wr_en_1   = w_wr_en_1;
   assign o_wr_en_2   = w_wr_en_2;
   assign o_addr_rd_1 = r_rd_1;
   assign o_addr_rd_2 = r_rd_2;
   assign o_data_rd_1 = r_mtr_1 ? r_mem_1 : r_alu_1;
   assign o_data_rd_2 = r_mtr_2 ? r_mem_2 : r_alu_2;
   assign o_valid_1   = r_valid_1;
   assign o_valid_2   = r_valid_2;
   assign o_retired   = r_retired;
endmodule
